smart_home_cmd_ctrl: RTL and testbench



---
 rtl/smart_home_cmd_ctrl.sv | 156 +++++++++++++++
 tb/tb_smart_home_cmd_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/smart_home_cmd_ctrl.sv
// Purpose  : N-channel command decoder driving on/off outputs plus a two-byte
//            status reporter (header byte, then channel states) sent periodically
//            and on request. Optional build macro: CMD_TOGGLE_EN adds per-channel
//            toggle codes.
// Latency  : a command strobed into edge n updates ch_out/cmd_err after edge n.
//            A status frame starts one cycle after its request is registered.
// Backpres.: tx_data/tx_valid hold until tx_valid && tx_ready. A request made
//            while a frame is in flight is remembered as one pending frame.
// Ports    : clk, rst_n (sync, active-low) | rx_data/rx_valid command input |
//            ch_out channel states | tx_data/tx_valid/tx_ready status output |
//            cmd_err one-cycle pulse on an unrecognised code.
module smart_home_cmd_ctrl #(
  parameter int          NUM_CH     = 4,
  parameter int          CMD_BASE   = 20,
  parameter int          CLK_HZ     = 50000000,
  parameter int          REPORT_MS  = 2000,
  parameter logic [7:0]  STATUS_HDR = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [NUM_CH-1:0] ch_out,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              cmd_err
);

  localparam int REPORT_CYCLES = CLK_HZ / 1000 * REPORT_MS;
  localparam int TW = (REPORT_CYCLES > 1) ? $clog2(REPORT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(REPORT_CYCLES - 1);

  localparam logic [8:0] REL_ALL_OFF = 9'(2 * NUM_CH);
  localparam logic [8:0] REL_STATUS  = 9'(2 * NUM_CH + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SEND_HDR = 2'd1;
  localparam logic [1:0] S_SEND_STA = 2'd2;

  logic [NUM_CH-1:0] ch_q, ch_d;
  logic [7:0]        txd_q, txd_d;
  logic              txv_q, txv_d;
  logic              err_q, err_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              pend_q, pend_d;
  logic [1:0]        st_q, st_d;

  logic [8:0] rel;
  logic       req_set;
  logic       frame_start;
  logic       tmr_wrap;
  logic [7:0] stat_byte;

  // Nine-bit difference: codes below CMD_BASE land at 256 and above, so they
  // can never fall into the channel code window.
  assign rel = {1'b0, rx_data} - 9'(CMD_BASE);

  always_comb begin
    ch_d    = ch_q;
    err_d   = 1'b0;
    req_set = 1'b0;
    if (rx_valid) begin
      if (rel < REL_ALL_OFF) begin
        // rel[0] selects OFF; rel[8:1] is the channel index.
        for (int k = 0; k < NUM_CH; k++) begin
          if (rel[8:1] == 8'(k)) ch_d[k] = ~rel[0];
        end
      end else if (rel == REL_ALL_OFF) begin
        ch_d = '0;
      end else if (rel == REL_STATUS) begin
        req_set = 1'b1;
`ifdef CMD_TOGGLE_EN
      end else if (rel >= 9'(2 * NUM_CH + 2) && rel < 9'(3 * NUM_CH + 2)) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (rel == 9'(2 * NUM_CH + 2 + k)) ch_d[k] = ~ch_q[k];
        end
`endif
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign tmr_wrap = (tmr_q == TMR_LAST);
  assign tmr_d    = tmr_wrap ? '0 : tmr_q + 1'b1;

  always_comb begin
    stat_byte = '0;
    stat_byte[NUM_CH-1:0] = ch_q;
  end

  always_comb begin
    st_d        = st_q;
    txd_d       = txd_q;
    txv_d       = txv_q;
    frame_start = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (pend_q) begin
          txd_d       = STATUS_HDR;
          txv_d       = 1'b1;
          frame_start = 1'b1;
          st_d        = S_SEND_HDR;
        end
      end
      S_SEND_HDR: begin
        // Status reflects the channels as they stand at the header handshake.
        if (tx_ready) begin
          txd_d = stat_byte;
          st_d  = S_SEND_STA;
        end
      end
      S_SEND_STA: begin
        if (tx_ready) begin
          txv_d = 1'b0;
          st_d  = S_IDLE;
        end
      end
      default: begin
        txv_d = 1'b0;
        st_d  = S_IDLE;
      end
    endcase
  end

  // A request arriving on the very edge a frame starts is served by that frame,
  // since its status byte is sampled later.
  assign pend_d = frame_start ? 1'b0 : (pend_q | req_set | tmr_wrap);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_q   <= '0;
      txd_q  <= '0;
      txv_q  <= 1'b0;
      err_q  <= 1'b0;
      tmr_q  <= '0;
      pend_q <= 1'b0;
      st_q   <= S_IDLE;
    end else begin
      ch_q   <= ch_d;
      txd_q  <= txd_d;
      txv_q  <= txv_d;
      err_q  <= err_d;
      tmr_q  <= tmr_d;
      pend_q <= pend_d;
      st_q   <= st_d;
    end
  end

  assign ch_out   = ch_q;
  assign tx_data  = txd_q;
  assign tx_valid = txv_q;
  assign cmd_err  = err_q;

endmodule

// File: tb/tb_smart_home_cmd_ctrl.sv
module tb_smart_home_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic [3:0] ch_out;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       cmd_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic       prev_v = 1'b0;
  logic [7:0] q_exp[$];
  int         rises[$];

  smart_home_cmd_ctrl #(
    .NUM_CH(4), .CMD_BASE(20), .CLK_HZ(50000), .REPORT_MS(2), .STATUS_HDR(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .ch_out(ch_out), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Scoreboard consumer: every accepted byte is popped and compared.
  always @(negedge clk) begin
    if (rst_n && tx_valid && !prev_v) rises.push_back(cyc);
    prev_v = rst_n && tx_valid;
    if (rst_n && tx_valid && tx_ready) begin
      tests++;
      if (q_exp.size() == 0) begin
        fails++;
        $display("FAIL unexpected_tx cyc=%0d got=%h required=none", cyc, tx_data);
      end else begin
        logic [7:0] e;
        e = q_exp.pop_front();
        if (tx_data !== e) begin
          fails++;
          $display("FAIL tx_byte cyc=%0d got=%h required=%h", cyc, tx_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    q_exp.delete();
    rises.delete();
  endtask

  task automatic send(input logic [7:0] c);
    @(posedge clk); #1;
    rx_data = c; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  // Strobe c during the cycle after edge n, so the DUT samples it at edge n+1.
  task automatic drive_at(input int n, input logic [7:0] c);
    wait_cyc(n);
    rx_data = c; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (ch_out !== 4'b0000) begin fails++; $display("FAIL reset_ch got=%b required=0000", ch_out); end
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_txv got=%b required=0", tx_valid); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_txd got=%h required=00", tx_data); end
    tests++; if (cmd_err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b required=0", cmd_err); end
  endtask

  task automatic test_onoff();
    logic [7:0] codes[4];
    logic [3:0] exp_ch[4];
    codes  = '{8'd20, 8'd24, 8'd26, 8'd21};
    exp_ch = '{4'b0001, 4'b0101, 4'b1101, 4'b1100};
    for (int i = 0; i < 4; i++) begin
      send(codes[i]);
      tests++;
      if (ch_out !== exp_ch[i] || cmd_err !== 1'b0) begin
        fails++;
        $display("FAIL onoff code=%0d got ch=%b err=%b required ch=%b err=0", codes[i], ch_out, cmd_err, exp_ch[i]);
      end
    end
  endtask

  task automatic test_ignore();
    rx_data = 8'd22;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    tests++; if (ch_out !== 4'b1100) begin fails++; $display("FAIL ignore_novalid got=%b required=1100", ch_out); end
    send(8'd28);
    tests++; if (ch_out !== 4'b0000) begin fails++; $display("FAIL all_off got=%b required=0000", ch_out); end
  endtask

  task automatic test_err();
    logic [7:0] bad[3];
    bad = '{8'd19, 8'd34, 8'd255};
    send(8'd20);
    for (int i = 0; i < 3; i++) begin
      send(bad[i]);
      tests++;
      if (cmd_err !== 1'b1 || ch_out !== 4'b0001) begin
        fails++;
        $display("FAIL err_pulse code=%0d got err=%b ch=%b required err=1 ch=0001", bad[i], cmd_err, ch_out);
      end
      @(posedge clk); #1;
      tests++; if (cmd_err !== 1'b0) begin fails++; $display("FAIL err_width code=%0d got=%b required=0", bad[i], cmd_err); end
    end
`ifdef CMD_TOGGLE_EN
    send(8'd30);
    tests++; if (ch_out !== 4'b0000 || cmd_err !== 1'b0) begin fails++; $display("FAIL toggle1 got ch=%b err=%b required ch=0000 err=0", ch_out, cmd_err); end
    send(8'd30);
    tests++; if (ch_out !== 4'b0001 || cmd_err !== 1'b0) begin fails++; $display("FAIL toggle2 got ch=%b err=%b required ch=0001 err=0", ch_out, cmd_err); end
    send(8'd33);
    tests++; if (ch_out !== 4'b1001 || cmd_err !== 1'b0) begin fails++; $display("FAIL toggle3 got ch=%b err=%b required ch=1001 err=0", ch_out, cmd_err); end
`else
    send(8'd30);
    tests++; if (ch_out !== 4'b0001 || cmd_err !== 1'b1) begin fails++; $display("FAIL toggle_off got ch=%b err=%b required ch=0001 err=1", ch_out, cmd_err); end
`endif
    send(8'd29);
    tests++; if (cmd_err !== 1'b0) begin fails++; $display("FAIL status_req_err got=%b required=0", cmd_err); end
  endtask

  task automatic test_periodic();
    do_reset();
    tx_ready = 1'b1;
    send(8'd22);
    send(8'd26);
    tests++; if (ch_out !== 4'b1010) begin fails++; $display("FAIL periodic_setup got=%b required=1010", ch_out); end
    q_exp.push_back(8'hA5); q_exp.push_back(8'h0A);
    q_exp.push_back(8'hA5); q_exp.push_back(8'h0A);
    wait_cyc(205);
    tests++; if (rises.size() !== 2) begin fails++; $display("FAIL periodic_count got=%0d required=2", rises.size()); end
    else begin
      tests++; if (rises[0] !== 101) begin fails++; $display("FAIL periodic_t1 got=%0d required=101", rises[0]); end
      tests++; if (rises[1] !== 201) begin fails++; $display("FAIL periodic_t2 got=%0d required=201", rises[1]); end
    end
    tests++; if (q_exp.size() !== 0) begin fails++; $display("FAIL periodic_drain got=%0d left required=0", q_exp.size()); end
    wait_cyc(290);
    tx_ready = 1'b0;
    wait_cyc(301);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
        fails++;
        $display("FAIL hold_hdr i=%0d got v=%b d=%h required v=1 d=a5", i, tx_valid, tx_data);
      end
      @(posedge clk); #1;
    end
    q_exp.push_back(8'hA5); q_exp.push_back(8'h0A);
    tx_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    tests++; if (q_exp.size() !== 0 || tx_valid !== 1'b0) begin fails++; $display("FAIL hold_release got left=%0d v=%b required left=0 v=0", q_exp.size(), tx_valid); end
  endtask

  task automatic test_status_req();
    do_reset();
    tx_ready = 1'b1;
    q_exp.push_back(8'hA5); q_exp.push_back(8'h00);
    drive_at(19, 8'd29);
    q_exp.push_back(8'hA5); q_exp.push_back(8'h00);
    drive_at(99, 8'd29);
    wait_cyc(190);
    tests++; if (rises.size() !== 2) begin fails++; $display("FAIL req_count got=%0d required=2", rises.size()); end
    else begin
      tests++; if (rises[0] !== 21) begin fails++; $display("FAIL req_t1 got=%0d required=21", rises[0]); end
      tests++; if (rises[1] !== 101) begin fails++; $display("FAIL req_coincide got=%0d required=101", rises[1]); end
    end
    tests++; if (q_exp.size() !== 0) begin fails++; $display("FAIL req_drain got=%0d left required=0", q_exp.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(8'd20);
    q_exp.push_back(8'hA5); q_exp.push_back(8'h01);
    q_exp.push_back(8'hA5); q_exp.push_back(8'h00);
    drive_at(10, 8'd29);
    drive_at(15, 8'd29);
    wait_cyc(25);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    drive_at(27, 8'd21);
    tests++; if (ch_out !== 4'b0000) begin fails++; $display("FAIL midframe_cmd got=%b required=0000", ch_out); end
    wait_cyc(30);
    tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin fails++; $display("FAIL captured_stat got v=%b d=%h required v=1 d=01", tx_valid, tx_data); end
    wait_cyc(35);
    tx_ready = 1'b1;
    wait_cyc(60);
    tests++; if (rises.size() !== 2) begin fails++; $display("FAIL b2b_count got=%0d required=2", rises.size()); end
    else begin
      tests++; if (rises[0] !== 12) begin fails++; $display("FAIL b2b_t1 got=%0d required=12", rises[0]); end
      tests++; if (rises[1] !== 37) begin fails++; $display("FAIL b2b_t2 got=%0d required=37", rises[1]); end
    end
    tests++; if (q_exp.size() !== 0) begin fails++; $display("FAIL b2b_drain got=%0d left required=0", q_exp.size()); end
  endtask

  task automatic test_reset_midframe();
    tx_ready = 1'b0;
    send(8'd24);
    drive_at(70, 8'd29);
    wait_cyc(75);
    tests++; if (tx_valid !== 1'b1) begin fails++; $display("FAIL midreset_pre got=%b required=1", tx_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || ch_out !== 4'b0000) begin fails++; $display("FAIL midreset got v=%b d=%h ch=%b required 0/00/0000", tx_valid, tx_data, ch_out); end
    rst_n = 1'b1;
    tx_ready = 1'b1;
    rises.delete();
    repeat (20) begin @(posedge clk); #1; end
    tests++; if (rises.size() !== 0 || tx_valid !== 1'b0) begin fails++; $display("FAIL midreset_after got rises=%0d v=%b required 0/0", rises.size(), tx_valid); end
  endtask

  initial begin
    test_reset();
    test_onoff();
    test_ignore();
    test_err();
    test_periodic();
    test_status_req();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
